// File: rtl/countdown_timer_bcd.sv
// BCD MM:SS countdown timer, decremented by a 1 Hz tick, with done pulse and alarm.
// Optional build macro: ALARM_BLINK_EN makes alarm toggle on each tick while in DONE.
module countdown_timer_bcd #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  min_t,
  output logic [3:0]  min_u,
  output logic [3:0]  sec_t,
  output logic [3:0]  sec_u,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int unsigned DW = 4;
  localparam int unsigned TW = 4 * DW;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] acnt_q, acnt_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic          running_q, running_d;
  logic [TW-1:0] load_clamped;
  logic [TW-1:0] cnt_dec;
  logic          cnt_zero;

  // Saturate each loaded digit to its legal BCD range.
  function automatic logic [TW-1:0] clamp_bcd(input logic [TW-1:0] v);
    logic [DW-1:0] mt, mu, st, su;
    mt = (v[15:12] > DW'(9)) ? DW'(9) : v[15:12];
    mu = (v[11:8]  > DW'(9)) ? DW'(9) : v[11:8];
    st = (v[7:4]   > DW'(5)) ? DW'(5) : v[7:4];
    su = (v[3:0]   > DW'(9)) ? DW'(9) : v[3:0];
    return {mt, mu, st, su};
  endfunction

  // One-second decrement with borrow through the digit chain.
  function automatic logic [TW-1:0] dec_bcd(input logic [TW-1:0] v);
    logic [DW-1:0] mt, mu, st, su;
    {mt, mu, st, su} = v;
    if (su == '0) begin
      su = DW'(9);
      if (st == '0) begin
        st = DW'(5);
        if (mu == '0) begin
          mu = DW'(9);
          mt = mt - DW'(1);
        end else begin
          mu = mu - DW'(1);
        end
      end else begin
        st = st - DW'(1);
      end
    end else begin
      su = su - DW'(1);
    end
    return {mt, mu, st, su};
  endfunction

  assign load_clamped = clamp_bcd(load_val);
  assign cnt_dec      = dec_bcd(cnt_q);
  assign cnt_zero     = (cnt_q == '0);

  // Next-state, digit and alarm logic; stop > load > start > tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (load) begin
          cnt_d = load_clamped;
        end else if (start && !cnt_zero) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            alarm_d = 1'b1;
            acnt_d  = '0;
          end
        end
      end
      S_DONE: begin
        if (stop || load || start) begin
          state_d = S_IDLE;
          alarm_d = 1'b0;
          acnt_d  = '0;
          if (!stop && load) begin
            cnt_d = load_clamped;
          end
        end else if (tick) begin
          if (acnt_q == CW'(ALARM_TICKS - 1)) begin
            state_d = S_IDLE;
            alarm_d = 1'b0;
            acnt_d  = '0;
          end else begin
            acnt_d = acnt_q + CW'(1);
`ifdef ALARM_BLINK_EN
            alarm_d = ~alarm_q;
`else
            alarm_d = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    running_d = (state_d == S_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acnt_q    <= '0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acnt_q    <= acnt_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
    end
  end

  assign min_t   = cnt_q[15:12];
  assign min_u   = cnt_q[11:8];
  assign sec_t   = cnt_q[7:4];
  assign sec_u   = cnt_q[3:0];
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- BCD MM:SS countdown timer for the digital clock module. It runs in the opposite direction to the up-counting clock digits.
- Decrements once per 1 Hz tick from a loaded value to 00:00, then raises done and alarm.
- Sits beside the clock counter chain and shares its clk and tick source; outputs drive the same 7-segment mux as the clock digits.

Parameters:
- ALARM_TICKS, 10, number of tick pulses alarm stays active in DONE before auto-return to IDLE (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- tick  input  1  one-clk-wide enable pulse, 1 per second.
- load  input  1  load load_val into digits.
- load_val  input  16  packed BCD {min_t, min_u, sec_t, sec_u}.
- start  input  1  begin/resume countdown.
- stop  input  1  pause countdown / cancel alarm.
- min_t  output  4  minutes tens digit (0-9).
- min_u  output  4  minutes units digit (0-9).
- sec_t  output  4  seconds tens digit (0-5).
- sec_u  output  4  seconds units digit (0-9).
- running  output  1  high in RUN.
- done  output  1  one-clk pulse on reaching 00:00.
- alarm  output  1  alarm indicator.

Behaviour:
- Reset: clk edge with rst=0 gives all digits 0, state IDLE, running=0, done=0, alarm=0, alarm tick counter 0. Reset mid-RUN or mid-DONE aborts immediately.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Load:
  - Accepted in IDLE, PAUSE, DONE; ignored in RUN.
  - Digits update on the next edge.
  - Load in DONE clears alarm and goes to IDLE.
  - Load in PAUSE stays in PAUSE.
- Load clamping: min_t>9 gives 9; min_u>9 gives 9; sec_t>5 gives 5; sec_u>9 gives 9.
- Start:
  - IDLE/PAUSE go to RUN if count != 00:00; start is ignored if count == 00:00.
  - Start in DONE clears alarm and goes to IDLE (no restart).
- Stop:
  - RUN goes to PAUSE.
  - DONE goes to IDLE, alarm cleared.
  - Ignored in IDLE/PAUSE.
- Priority in one cycle: rst > stop > load > start > tick. Load and start together in IDLE: load applied, start ignored.
- Tick in RUN (no stop): decrement one second with borrow chain.
  - sec_u 0 gives 9 and borrows, else -1.
  - sec_t 0 gives 5 and borrows, else -1.
  - min_u 0 gives 9 and borrows, else -1.
  - min_t -1 only on borrow.
- Latency: digits change on the edge at which tick=1 is sampled.
- Zero reached:
  - When the decrement yields 00:00, state goes to DONE on the same edge.
  - done=1 for exactly that following cycle.
  - alarm=1 from that edge.
  - Digits stay at 00:00.
- DONE:
  - Each tick increments the alarm counter.
  - On the ALARM_TICKS-th tick: alarm=0, counter cleared, state goes to IDLE.
- Tick outside RUN/DONE: no effect.
- Counting from 99:59 is legal; 00:00 can never wrap to 99:59.
- running is 1 exactly when state==RUN.

Optional Feature:
- Macro ALARM_BLINK_EN.
- Defined: alarm toggles on every tick while in DONE, starting at 1 on entry. It is forced 0 on exit to IDLE.
- Undefined: alarm is steady high throughout DONE.
- Auto-return after ALARM_TICKS is identical in both builds.

Test Plan:
- Reset: hold rst=0 two cycles mid-RUN -> digits 00:00, running=0, done=0, alarm=0.
- Load 0x0102 (01:02) in IDLE, start, 3 ticks -> 01:01, 01:00, 00:59.
- Load 0x0003, start, 3 ticks -> 00:02, 00:01, 00:00. done high exactly one cycle, alarm=1, running=0. After 10 more ticks -> alarm=0, IDLE.
- Run 00:30, assert stop and tick same cycle -> digits stay 00:30, PAUSE. Load 0x0010 while paused -> 00:10. Start -> resumes.
- Load 0xFF7F -> clamped 99:59. Start in IDLE with 00:00 -> stays IDLE, running=0.
- With ALARM_BLINK_EN, countdown to 00:00 then 4 ticks -> alarm 1,0,1,0,1 sequence. Stop -> alarm=0, IDLE.
